mini_alu_core_p: RTL and testbench

- Parametrised successor to the MiniAlu execution core: a two-stage (fetch / execute) accumulator-less register machine.
- Fetches from an external instruction ROM and executes ALU, branch, LED and output instructions.
- New over the previous generation:
  - configurable data, field, PC and LED widths;
  - hardware return-address stack for CALL/RET, with overflow/underflow faults;
  - one-entry output buffer with valid/ready handshake that stalls the pipeline;
  - HALT and fault state.
- Sits between the instruction ROM and peripheral controllers (LCD/VGA writers attach to the output channel).

---
 rtl/mini_alu_core_p.sv | 213 +++++++++++++++++++++
 tb/tb_mini_alu_core_p.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mini_alu_core_p.sv
// ----------------------------------------------------------------------------
// mini_alu_core_p
//   Two-stage (fetch / execute) register-machine core. Fetches from an
//   external instruction ROM and executes ALU, branch, LED and output
//   instructions. It has a hardware return-address stack, a one-entry output
//   buffer with a valid/ready handshake, and a HALT/fault state.
//
// Ports
//   Clock         in   system clock, all state on the rising edge
//   Reset         in   asynchronous, active-low reset
//   oIP           out  instruction fetch address (registered PC)
//   iInstruction  in   ROM word for oIP: [op 4][dest F][src1 F][src0 F]
//   oLed          out  LED register
//   oOutData      out  output buffer data
//   oOutValid     out  output buffer full
//   iOutReady     in   consumer takes oOutData when high together with oOutValid
//   oHalted       out  core is in HALT
//   oFault        out  0 none, 1 stack overflow, 2 stack underflow, 3 illegal op
// ----------------------------------------------------------------------------
module mini_alu_core_p #(
   parameter int DATA_WIDTH  = 16,
   parameter int FIELD_WIDTH = 8,
   parameter int PC_WIDTH    = 16,
   parameter int STACK_DEPTH = 8,
   parameter int LED_WIDTH   = 8
) (
   input  logic                         Clock,
   input  logic                         Reset,
   output logic [PC_WIDTH-1:0]          oIP,
   input  logic [4+3*FIELD_WIDTH-1:0]   iInstruction,
   output logic [LED_WIDTH-1:0]         oLed,
   output logic [DATA_WIDTH-1:0]        oOutData,
   output logic                         oOutValid,
   input  logic                         iOutReady,
   output logic                         oHalted,
   output logic [1:0]                   oFault
);

   localparam int IW    = 4 + 3*FIELD_WIDTH;
   localparam int IDX_W = $clog2(STACK_DEPTH);
   localparam int SP_W  = IDX_W + 1;
   localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_STO  = 4'd3;
   localparam logic [3:0] OP_BLE  = 4'd4;
   localparam logic [3:0] OP_JMP  = 4'd5;
   localparam logic [3:0] OP_CALL = 4'd6;
   localparam logic [3:0] OP_RET  = 4'd7;
   localparam logic [3:0] OP_LED  = 4'd8;
   localparam logic [3:0] OP_MUL  = 4'd9;
   localparam logic [3:0] OP_OUT  = 4'd10;
   localparam logic [3:0] OP_HALT = 4'd15;

   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_HALT = 1'b1;

   localparam logic [1:0] FLT_NONE  = 2'd0;
   localparam logic [1:0] FLT_OVER  = 2'd1;
   localparam logic [1:0] FLT_UNDER = 2'd2;
   localparam logic [1:0] FLT_ILL   = 2'd3;

   logic [PC_WIDTH-1:0]    pc;
   logic [IW-1:0]          ir;
   logic [0:0]             state;
   logic [SP_W-1:0]        sp;

   logic [DATA_WIDTH-1:0]  regs [2**FIELD_WIDTH];
   logic [PC_WIDTH-1:0]    ras  [STACK_DEPTH];

   // Instruction fields of the word in the execute stage.
   logic [3:0]             op;
   logic [FIELD_WIDTH-1:0] dest, src1, src0;
   logic [2*FIELD_WIDTH-1:0] imm_raw;
   logic [DATA_WIDTH-1:0]  rd1, rd0;
   logic [IDX_W-1:0]       top_idx;

   assign op      = ir[IW-1 -: 4];
   assign dest    = ir[3*FIELD_WIDTH-1 -: FIELD_WIDTH];
   assign src1    = ir[2*FIELD_WIDTH-1 -: FIELD_WIDTH];
   assign src0    = ir[FIELD_WIDTH-1:0];
   assign imm_raw = ir[2*FIELD_WIDTH-1:0];

   // Combinational reads: a write at this edge is seen by the next
   // instruction, so dependent back-to-back instructions need no interlock.
   assign rd1     = regs[src1];
   assign rd0     = regs[src0];
   assign top_idx = IDX_W'(sp - 1'b1);

   logic                   take, stall, halt_req, advance;
   logic                   wr_en, push, pop, led_we, out_load;
   logic [PC_WIDTH-1:0]    target;
   logic [DATA_WIDTH-1:0]  wr_data;
   logic [1:0]             fault_code;

   // NOTE: every signal gets a default before the case so no path leaves one
   // unassigned; otherwise synthesis infers a latch.
   always_comb begin
      take       = 1'b0;
      stall      = 1'b0;
      halt_req   = 1'b0;
      wr_en      = 1'b0;
      push       = 1'b0;
      pop        = 1'b0;
      led_we     = 1'b0;
      out_load   = 1'b0;
      target     = pc;
      wr_data    = '0;
      fault_code = FLT_NONE;
      if (state == ST_RUN) begin
         case (op)
            OP_NOP: ;
            OP_ADD: begin wr_en = 1'b1; wr_data = rd1 + rd0; end
            OP_SUB: begin wr_en = 1'b1; wr_data = rd1 - rd0; end
            OP_MUL: begin wr_en = 1'b1; wr_data = rd1 * rd0; end
            OP_STO: begin wr_en = 1'b1; wr_data = DATA_WIDTH'(imm_raw); end
            OP_BLE: begin
               if (rd1 <= rd0) begin
                  take   = 1'b1;
                  target = PC_WIDTH'(dest);
               end
            end
            OP_JMP: begin take = 1'b1; target = PC_WIDTH'(imm_raw); end
            OP_CALL: begin
               // A full stack faults without pushing or jumping.
               if (sp == SP_FULL) begin
                  halt_req   = 1'b1;
                  fault_code = FLT_OVER;
               end else begin
                  push   = 1'b1;
                  take   = 1'b1;
                  target = PC_WIDTH'(imm_raw);
               end
            end
            OP_RET: begin
               if (sp == '0) begin
                  halt_req   = 1'b1;
                  fault_code = FLT_UNDER;
               end else begin
                  pop    = 1'b1;
                  take   = 1'b1;
                  target = ras[top_idx];
               end
            end
            OP_LED: led_we = 1'b1;
            OP_OUT: begin
               // A full buffer that is not drained this cycle holds the pipe;
               // if it is drained this cycle the new word replaces it.
               if (oOutValid && !iOutReady) stall    = 1'b1;
               else                         out_load = 1'b1;
            end
            OP_HALT: halt_req = 1'b1;
            default: begin
               halt_req   = 1'b1;
               fault_code = FLT_ILL;
            end
         endcase
      end
   end

   assign advance = (state == ST_RUN) && !stall && !halt_req;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         pc        <= '0;
         ir        <= '0;
         state     <= ST_RUN;
         sp        <= '0;
         oLed      <= '0;
         oOutData  <= '0;
         oOutValid <= 1'b0;
         oFault    <= FLT_NONE;
      end else begin
         if (advance) begin
            if (take) begin
               // Discard the already fetched word: one bubble.
               pc <= target;
               ir <= '0;
            end else begin
               pc <= pc + 1'b1;
               ir <= iInstruction;
            end
         end
         if (halt_req)                state  <= ST_HALT;
         if (fault_code != FLT_NONE)  oFault <= fault_code;
         if (push)                    sp     <= sp + 1'b1;
         else if (pop)                sp     <= sp - 1'b1;
         if (led_we)                  oLed   <= rd1[LED_WIDTH-1:0];
         // The buffer keeps draining in HALT.
         if (out_load) begin
            oOutData  <= rd0;
            oOutValid <= 1'b1;
         end else if (oOutValid && iOutReady) begin
            oOutValid <= 1'b0;
         end
      end
   end

   // NOTE: register file and return stack are plain storage with no reset;
   // software must write a register before reading it.
   always_ff @(posedge Clock) begin
      if (wr_en) regs[dest]                <= wr_data;
      if (push)  ras[sp[IDX_W-1:0]]        <= pc;
   end

   assign oIP     = pc;
   assign oHalted = (state == ST_HALT);

endmodule

// File: tb/tb_mini_alu_core_p.sv
// ----------------------------------------------------------------------------
// tb_mini_alu_core_p
//   Directed bench for mini_alu_core_p with default parameters. A ROM array
//   feeds iInstruction from oIP; accepted output words are captured in a
//   queue for comparison against hand-computed values.
// ----------------------------------------------------------------------------
module tb_mini_alu_core_p;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic [15:0] oIP;
   logic [27:0] iInstruction;
   logic [7:0]  oLed;
   logic [15:0] oOutData;
   logic        oOutValid;
   logic        iOutReady = 1'b0;
   logic        oHalted;
   logic [1:0]  oFault;

   int assert_cnt = 0;
   int fail_cnt   = 0;

   logic [27:0] rom [256];
   logic [15:0] out_q [$];

   mini_alu_core_p dut (
      .Clock        (Clock),
      .Reset        (Reset),
      .oIP          (oIP),
      .iInstruction (iInstruction),
      .oLed         (oLed),
      .oOutData     (oOutData),
      .oOutValid    (oOutValid),
      .iOutReady    (iOutReady),
      .oHalted      (oHalted),
      .oFault       (oFault)
   );

   always #5 Clock = ~Clock;

   assign iInstruction = rom[oIP[7:0]];

   // Words accepted at the next rising edge.
   always @(negedge Clock)
      if (Reset && oOutValid && iOutReady) out_q.push_back(oOutData);

   function automatic logic [27:0] ins(input logic [3:0] op, input logic [7:0] d,
                                       input logic [7:0] s1, input logic [7:0] s0);
      return {op, d, s1, s0};
   endfunction

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = 28'h0;
   endtask

   // Holds reset over two edges, releases 1 ns after an edge; the next edge
   // is the first fetch.
   task automatic start_core();
      Reset     = 1'b0;
      iOutReady = 1'b0;
      out_q.delete();
      repeat (2) tick();
      Reset = 1'b1;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      #2;
      Reset = 1'b0;
      #1;
      assert_cnt++;
      if ({oIP, oLed, oOutData, oOutValid, oHalted, oFault} !== 45'h0) begin
         $display("FAIL reset_state: got ip=%h led=%h data=%h v=%b h=%b f=%0d expected all zero",
                  oIP, oLed, oOutData, oOutValid, oHalted, oFault);
         fail_cnt++;
      end
   endtask

   task automatic test_alu();
      clear_rom();
      rom[0]  = ins(3, 1, 0, 5);        // STO R1,5
      rom[1]  = ins(3, 2, 0, 3);        // STO R2,3
      rom[2]  = ins(1, 3, 1, 2);        // ADD R3=R1+R2
      rom[3]  = ins(8, 0, 3, 0);        // LED R3
      rom[4]  = ins(2, 4, 2, 1);        // SUB R4=R2-R1
      rom[5]  = ins(10, 0, 0, 4);       // OUT R4
      rom[6]  = ins(3, 5, 8'h01, 8'h00);// STO R5,0x0100
      rom[7]  = ins(9, 6, 5, 5);        // MUL R6=R5*R5
      rom[8]  = ins(10, 0, 0, 6);       // OUT R6
      rom[9]  = ins(10, 0, 0, 3);       // OUT R3 (reload while draining)
      rom[10] = ins(15, 0, 0, 0);       // HALT
      start_core();
      iOutReady = 1'b1;
      repeat (4) tick();
      assert_cnt++;
      if (oLed !== 8'h00) begin
         $display("FAIL led_before: got %h expected 00", oLed); fail_cnt++;
      end
      tick();
      assert_cnt++;
      if (oLed !== 8'h08) begin
         $display("FAIL led_add: got %h expected 08", oLed); fail_cnt++;
      end
      repeat (15) tick();
      assert_cnt++;
      if (out_q.size() !== 3) begin
         $display("FAIL alu_out_count: got %0d expected 3", out_q.size()); fail_cnt++;
      end else begin
         assert_cnt++;
         if (out_q[0] !== 16'hFFFE) begin
            $display("FAIL sub_wrap: got %h expected fffe", out_q[0]); fail_cnt++;
         end
         assert_cnt++;
         if (out_q[1] !== 16'h0000) begin
            $display("FAIL mul_trunc: got %h expected 0000", out_q[1]); fail_cnt++;
         end
         assert_cnt++;
         if (out_q[2] !== 16'h0008) begin
            $display("FAIL out_reload: got %h expected 0008", out_q[2]); fail_cnt++;
         end
      end
      assert_cnt++;
      if ({oHalted, oFault, oIP} !== {1'b1, 2'd0, 16'd11}) begin
         $display("FAIL alu_halt: got h=%b f=%0d ip=%h expected h=1 f=0 ip=000b",
                  oHalted, oFault, oIP);
         fail_cnt++;
      end
   endtask

   task automatic test_branch();
      logic [15:0] exp_ip [17];
      exp_ip = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd3, 16'd4, 16'd5, 16'd3,
                 16'd4, 16'd5, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd7};
      clear_rom();
      rom[0] = ins(3, 1, 0, 0);         // STO R1,0
      rom[1] = ins(3, 2, 0, 1);         // STO R2,1
      rom[2] = ins(3, 3, 0, 3);         // STO R3,3
      rom[3] = ins(1, 1, 1, 2);         // ADD R1+=R2
      rom[4] = ins(4, 3, 1, 3);         // BLE R1<=R3 -> 3
      rom[5] = ins(10, 0, 0, 1);        // OUT R1
      rom[6] = ins(15, 0, 0, 0);        // HALT
      start_core();
      iOutReady = 1'b1;
      for (int i = 0; i < 17; i++) begin
         tick();
         assert_cnt++;
         if (oIP !== exp_ip[i]) begin
            $display("FAIL branch_ip[%0d]: got %h expected %h", i, oIP, exp_ip[i]);
            fail_cnt++;
         end
      end
      tick();
      assert_cnt++;
      if (out_q.size() !== 1 || out_q[0] !== 16'd4) begin
         $display("FAIL loop_count: got n=%0d w=%h expected n=1 w=0004",
                  out_q.size(), (out_q.size() > 0) ? out_q[0] : 16'hxxxx);
         fail_cnt++;
      end
      assert_cnt++;
      if (oHalted !== 1'b1) begin
         $display("FAIL loop_halt: got %b expected 1", oHalted); fail_cnt++;
      end
   endtask

   task automatic test_call_ret();
      logic [15:0] exp_ip [10];
      exp_ip = '{16'h01, 16'h10, 16'h11, 16'h20, 16'h21, 16'h22, 16'h11, 16'h12,
                 16'h13, 16'h13};
      clear_rom();
      rom[8'h00] = ins(5, 0, 8'h00, 8'h10);  // JMP 0x10
      rom[8'h10] = ins(6, 0, 8'h00, 8'h20);  // CALL 0x20
      rom[8'h11] = ins(10, 0, 0, 7);         // OUT R7
      rom[8'h12] = ins(15, 0, 0, 0);         // HALT
      rom[8'h20] = ins(3, 7, 8'h12, 8'h34);  // STO R7,0x1234
      rom[8'h21] = ins(7, 0, 0, 0);          // RET
      start_core();
      iOutReady = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         assert_cnt++;
         if (oIP !== exp_ip[i]) begin
            $display("FAIL call_ip[%0d]: got %h expected %h", i, oIP, exp_ip[i]);
            fail_cnt++;
         end
      end
      assert_cnt++;
      if (out_q.size() !== 1 || out_q[0] !== 16'h1234 || oFault !== 2'd0) begin
         $display("FAIL call_ret_out: got n=%0d f=%0d expected n=1 w=1234 f=0",
                  out_q.size(), oFault);
         fail_cnt++;
      end
   endtask

   task automatic test_stack_overflow();
      clear_rom();
      for (int i = 0; i < 9; i++) rom[i] = ins(6, 0, 8'h00, 8'(i + 1)); // CALL i+1
      start_core();
      repeat (25) tick();
      assert_cnt++;
      if ({oFault, oHalted, oIP} !== {2'd1, 1'b1, 16'd9}) begin
         $display("FAIL overflow: got f=%0d h=%b ip=%h expected f=1 h=1 ip=0009",
                  oFault, oHalted, oIP);
         fail_cnt++;
      end
      repeat (5) tick();
      assert_cnt++;
      if (oIP !== 16'd9) begin
         $display("FAIL overflow_frozen: got %h expected 0009", oIP); fail_cnt++;
      end
   endtask

   task automatic test_stack_underflow();
      clear_rom();
      rom[0] = ins(7, 0, 0, 0);         // RET at depth 0
      start_core();
      repeat (4) tick();
      assert_cnt++;
      if ({oFault, oHalted, oIP} !== {2'd2, 1'b1, 16'd1}) begin
         $display("FAIL underflow: got f=%0d h=%b ip=%h expected f=2 h=1 ip=0001",
                  oFault, oHalted, oIP);
         fail_cnt++;
      end
   endtask

   task automatic test_illegal();
      clear_rom();
      rom[0] = ins(3, 1, 0, 1);         // STO R1,1
      rom[1] = ins(12, 1, 0, 0);        // illegal
      rom[2] = ins(5, 0, 0, 0);         // JMP 0 (never reached)
      start_core();
      repeat (6) tick();
      assert_cnt++;
      if ({oFault, oHalted, oIP} !== {2'd3, 1'b1, 16'd2}) begin
         $display("FAIL illegal: got f=%0d h=%b ip=%h expected f=3 h=1 ip=0002",
                  oFault, oHalted, oIP);
         fail_cnt++;
      end
   endtask

   task automatic load_out_program();
      clear_rom();
      rom[0] = ins(3, 1, 8'hAA, 8'hAA); // STO R1,0xAAAA
      rom[1] = ins(3, 2, 8'h55, 8'h55); // STO R2,0x5555
      rom[2] = ins(10, 0, 0, 1);        // OUT R1
      rom[3] = ins(10, 0, 0, 2);        // OUT R2 (stalls)
      rom[4] = ins(3, 3, 8'h00, 8'h77); // STO R3,0x77
      rom[5] = ins(8, 0, 3, 0);         // LED R3
      rom[6] = ins(15, 0, 0, 0);        // HALT
   endtask

   task automatic test_back_to_back_out();
      load_out_program();
      start_core();
      repeat (4) tick();
      for (int i = 0; i < 3; i++) begin
         tick();
         assert_cnt++;
         if ({oIP, oOutData, oOutValid, oLed} !== {16'd4, 16'hAAAA, 1'b1, 8'h00}) begin
            $display("FAIL stall[%0d]: got ip=%h d=%h v=%b led=%h expected ip=0004 d=aaaa v=1 led=00",
                     i, oIP, oOutData, oOutValid, oLed);
            fail_cnt++;
         end
      end
      iOutReady = 1'b1;
      tick();
      iOutReady = 1'b0;
      assert_cnt++;
      if ({oIP, oOutData, oOutValid} !== {16'd5, 16'h5555, 1'b1}) begin
         $display("FAIL accept_reload: got ip=%h d=%h v=%b expected ip=0005 d=5555 v=1",
                  oIP, oOutData, oOutValid);
         fail_cnt++;
      end
      assert_cnt++;
      if (out_q.size() !== 1 || out_q[0] !== 16'hAAAA) begin
         $display("FAIL first_word: got n=%0d expected n=1 w=aaaa", out_q.size());
         fail_cnt++;
      end
      repeat (4) tick();
      assert_cnt++;
      if ({oLed, oHalted, oOutValid, oOutData, oIP} !== {8'h77, 1'b1, 1'b1, 16'h5555, 16'd7}) begin
         $display("FAIL halt_hold: got led=%h h=%b v=%b d=%h ip=%h expected led=77 h=1 v=1 d=5555 ip=0007",
                  oLed, oHalted, oOutValid, oOutData, oIP);
         fail_cnt++;
      end
      iOutReady = 1'b1;
      tick();
      iOutReady = 1'b0;
      assert_cnt++;
      if (oOutValid !== 1'b0 || out_q.size() !== 2) begin
         $display("FAIL halt_drain: got v=%b n=%0d expected v=0 n=2", oOutValid, out_q.size());
         fail_cnt++;
      end
   endtask

   task automatic test_reset_mid_stall();
      load_out_program();
      start_core();
      repeat (6) tick();
      assert_cnt++;
      if ({oIP, oOutValid} !== {16'd4, 1'b1}) begin
         $display("FAIL pre_reset_stall: got ip=%h v=%b expected ip=0004 v=1", oIP, oOutValid);
         fail_cnt++;
      end
      #2;
      Reset = 1'b0;
      #1;
      assert_cnt++;
      if ({oIP, oLed, oOutData, oOutValid, oHalted, oFault} !== 45'h0) begin
         $display("FAIL async_reset: got ip=%h led=%h d=%h v=%b h=%b f=%0d expected all zero",
                  oIP, oLed, oOutData, oOutValid, oHalted, oFault);
         fail_cnt++;
      end
      tick();
      Reset = 1'b1;
      tick();
      assert_cnt++;
      if (oIP !== 16'd1) begin
         $display("FAIL refetch: got %h expected 0001", oIP); fail_cnt++;
      end
      tick();
      assert_cnt++;
      if (oIP !== 16'd2) begin
         $display("FAIL refetch_next: got %h expected 0002", oIP); fail_cnt++;
      end
   endtask

   initial begin
      clear_rom();
      test_reset();
      test_alu();
      test_branch();
      test_call_ret();
      test_stack_overflow();
      test_stack_underflow();
      test_illegal();
      test_back_to_back_out();
      test_reset_mid_stall();
      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule
